// File: rtl/ife_commit_ctrl.sv
// rtl/ife_commit_ctrl.sv - in-order dual-core commit sequencer with compare, flush and serial re-execution
module ife_commit_ctrl #(
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int QUEUE_DEPTH    = 4,
  parameter int CNT_WIDTH      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid,
  input  logic [BLOCK_ID_WIDTH-1:0] disp_block_id,
  output logic                      disp_ready,
  input  logic                      core0_done,
  input  logic                      core1_done,
  output logic                      cmp_valid,
  output logic [BLOCK_ID_WIDTH-1:0] cmp_block_id,
  input  logic                      cmp_ok,
  input  logic                      cmp_fail,
  output logic                      serial_req,
  output logic [BLOCK_ID_WIDTH-1:0] serial_block_id,
  input  logic                      serial_done,
  output logic                      flush,
  output logic                      commit_valid,
  output logic [BLOCK_ID_WIDTH-1:0] commit_block_id,
  output logic                      commit_serial,
  output logic [CNT_WIDTH-1:0]      occupancy,
  output logic [15:0]               fail_count,
  output logic                      proto_err
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, CMP, SER} state_t;

  state_t                    state;
  logic [BLOCK_ID_WIDTH-1:0] mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_WIDTH-1:0]      cnt0;
  logic [CNT_WIDTH-1:0]      cnt1;
  logic [BLOCK_ID_WIDTH-1:0] head;

  logic push, pop, cmp_pass, cmp_bad, ser_pop, track;
  logic ovf0, ovf1, inc0, inc1;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 inc,
    input logic                 dec,
    input logic                 clr
  );
    logic [CNT_WIDTH-1:0] n;
    n = c;
    if (clr)
      n = '0;
    else if (inc && !dec)
      n = c + CNT_WIDTH'(1);
    else if (!inc && dec)
      n = c - CNT_WIDTH'(1);
    return n;
  endfunction

  assign head            = mem[rd_ptr];
  assign disp_ready      = (occupancy < CNT_WIDTH'(QUEUE_DEPTH)) && (state != SER);
  assign cmp_valid       = (state == CMP);
  assign serial_req      = (state == SER);
  assign cmp_block_id    = cmp_valid  ? head : '0;
  assign serial_block_id = serial_req ? head : '0;

  assign push     = disp_valid && disp_ready;
  assign cmp_pass = (state == CMP) && cmp_ok && !cmp_fail;
  assign cmp_bad  = (state == CMP) && !(cmp_ok && !cmp_fail);
  assign ser_pop  = (state == SER) && serial_done;
  assign pop      = cmp_pass || ser_pop;

  // Completions only count while speculative work is live (not in SER, not on the flush edge).
  assign track = (state != SER) && !cmp_bad;
  assign ovf0  = track && core0_done && (cnt0 == occupancy);
  assign ovf1  = track && core1_done && (cnt1 == occupancy);
  assign inc0  = track && core0_done && !ovf0;
  assign inc1  = track && core1_done && !ovf1;

  always_ff @(posedge clk) begin
    if (push && !cmp_bad)
      mem[wr_ptr] <= disp_block_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occupancy       <= '0;
      cnt0            <= '0;
      cnt1            <= '0;
      fail_count      <= '0;
      proto_err       <= 1'b0;
      flush           <= 1'b0;
      commit_valid    <= 1'b0;
      commit_serial   <= 1'b0;
      commit_block_id <= '0;
    end else begin
      flush         <= 1'b0;
      commit_valid  <= 1'b0;
      commit_serial <= 1'b0;

      cnt0 <= cnt_next(cnt0, inc0, cmp_pass, cmp_bad);
      cnt1 <= cnt_next(cnt1, inc1, cmp_pass, cmp_bad);

      if (ovf0 || ovf1 || ((state == CMP) && (cmp_ok == cmp_fail)))
        proto_err <= 1'b1;

      // Flush keeps only the head; any same-cycle dispatch is younger work and is dropped too.
      if (cmp_bad) begin
        wr_ptr    <= rd_ptr + PTR_W'(1);
        occupancy <= CNT_WIDTH'(1);
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)
          occupancy <= occupancy + CNT_WIDTH'(1);
        else if (!push && pop)
          occupancy <= occupancy - CNT_WIDTH'(1);
      end

      if (pop) begin
        commit_valid    <= 1'b1;
        commit_block_id <= head;
        commit_serial   <= ser_pop;
      end

      case (state)
        IDLE: begin
          if ((occupancy != '0) && (cnt0 != '0) && (cnt1 != '0))
            state <= CMP;
        end
        CMP: begin
          if (cmp_pass) begin
            state <= IDLE;
          end else begin
            state <= SER;
            flush <= 1'b1;
            if (fail_count != 16'hFFFF)
              fail_count <= fail_count + 16'd1;
          end
        end
        SER: begin
          if (serial_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
